wrr_grant_scheduler: RTL
========================

Name: wrr_grant_scheduler

Overview:
- Weighted round-robin grant scheduler for the shared result path: N valid/ready producers compete for one result channel.
- Replaces the fixed-priority engine.
- Issues a registered one-hot grant and holds it until the consumer acknowledges a transfer.
- Each requester gets up to WEIGHT consecutive transfers per round; weights are runtime-programmable.

Parameters:
- NREQ, 3: number of requesters.
- WEIGHT_W, 4: width of weight and credit fields.
- DEFAULT_WEIGHT, 1: weight and credit loaded at reset.
- TIMEOUT, 255: cycles a grant may sit unacknowledged (optional feature only).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester valid.
- ack  in  1  consumer accepted the granted word this cycle.
- wt_wr  in  1  weight write strobe.
- wt_idx  in  $clog2(NREQ)  requester index for weight write.
- wt_data  in  WEIGHT_W  new weight; 0 is treated as 1.
- grant  out  NREQ  one-hot grant, registered.
- grant_valid  out  1  OR of grant.
- grant_id  out  $clog2(NREQ)  binary index of grant; 0 when idle.
- ready  out  NREQ  grant & {NREQ{ack}}, combinational.
- timeout_pulse  out  1  one-cycle pulse on forced release (tied 0 without the optional feature).

Behaviour:
- Reset:
  - grant=0, grant_valid=0, grant_id=0, timeout_pulse=0.
  - rr_ptr=0; weight[i]=credit[i]=DEFAULT_WEIGHT; state=IDLE.
- States: IDLE (no grant), GRANT (grant held).
- Arbitration function pick(start):
  - Eligible set E = req & (credit!=0).
  - First set bit of E searching circularly from index start.
  - If E empty but req!=0: all credits reload from weights and the search repeats with reloaded credits in the same cycle.
- IDLE:
  - If req!=0, grant <= pick(rr_ptr) next cycle; go to GRANT.
  - Latency from req rising to grant is 1 cycle.
- GRANT, granted index g:
  - ack=1: credit[g] decrements.
    - If credit[g]-1 != 0 and req[g] is still 1, grant holds on g (burst, zero bubble).
    - Otherwise rr_ptr <= g+1 mod NREQ and grant <= pick(g+1) the same edge (back-to-back, no idle cycle).
    - If req is 0 after excluding g, go to IDLE.
  - ack=0 and req[g]=0 (withdrawal): grant drops next cycle; credit and rr_ptr unchanged; go to IDLE, or re-pick if other requests are pending.
  - ack=0 and req[g]=1: hold.
- Sampling: req is sampled on the same edge as ack; a requester dropping req on its ack cycle is excluded from the re-pick.
- Weight writes:
  - Update weight[] only; take effect at the next reload.
  - A write on a reload cycle: the reload uses the old value.
- Credit arithmetic: saturating at 0, WEIGHT_W wide; reload always loads max(weight,1).
- Fairness bound: a continuously requesting input waits at most sum of the other weights in transfers.
- ack when grant_valid=0 is ignored.
- Reset asserted mid-burst: immediate return to reset values; no partial credit retained.

Optional Feature:
- Macro: WRR_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) counts GRANT cycles without ack and clears on ack or grant change.
  - At TIMEOUT: grant is force-released, timeout_pulse=1 for one cycle, credit[g] is zeroed, rr_ptr <= g+1, and the next grant is picked the following cycle.
- Undefined: no counter; timeout_pulse tied 0; grant may be held indefinitely.

Decomposition:
- Package wrr_sched_pkg: state enum (IDLE, GRANT), ID_W = $clog2(NREQ) helper function, and onehot-to-index function.
- Sub-module rr_pick: combinational circular first-set finder (inputs: eligible vector, start index; outputs: one-hot and found). Instantiated twice: credit-eligible search and post-reload search.

Test Plan:
- Reset, then req=3'b001 on cycle 0 -> grant=001, grant_id=0 on cycle 1; ack each cycle gives continuous ready[0] with no bubble.
- Weights {a=3,b=1,c=1}, all req held, ack every cycle -> grant sequence a,a,a,b,c,a,a,a,b,c repeating; no idle cycle between grants.
- req=3'b110, grant on b, b drops req without ack -> grant switches to c one cycle later; credit[b] unchanged (checked when b re-requests).
- Write weight b=0 mid-round -> current round uses old weight; next round b gets exactly 1 transfer.
- Reset asserted while grant=010 mid-burst -> grant=0, grant_id=0 asynchronously; after release, req=111 -> first grant is a.
- WRR_TIMEOUT_EN with TIMEOUT=4: grant c, no ack for 4 cycles -> timeout_pulse high 1 cycle, grant moves to a on the next cycle.

Source files
------------

// File: rtl/wrr_sched_pkg.sv
// Shared types and helpers for the weighted round-robin grant scheduler.
// Optional watchdog feature macro: WRR_TIMEOUT_EN (used by wrr_grant_scheduler).
package wrr_sched_pkg;

  // Scheduler states: no grant outstanding, or a grant being held.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Binary index of the lowest set bit; 0 for an all-zero vector.
  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_grant_scheduler_rr_pick.sv
// Circular first-set finder: returns the first eligible bit at or after
// 'start', wrapping around, as a one-hot vector plus a found flag.
module rr_pick
  import wrr_sched_pkg::*;
#(
  parameter int N   = 3,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   elig,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   onehot,
  output logic           found
);

  // Scan by circular distance from start; the nearest eligible bit wins.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && elig[i] && (((i + N - int'(start)) % N) == k)) begin
          onehot[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin grant scheduler for the shared result channel.
// Grants are registered and one-hot; each requester may take up to its
// programmed weight of consecutive transfers per round.
// Optional feature macro: WRR_TIMEOUT_EN (force-release of an unacknowledged
// grant after TIMEOUT cycles). Without it timeout_pulse is tied low.
module wrr_grant_scheduler
  import wrr_sched_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int WEIGHT_W       = 4,
  parameter int DEFAULT_WEIGHT = 1,
  parameter int TIMEOUT        = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  input  logic                        ack,
  input  logic                        wt_wr,
  input  logic [id_width(NREQ)-1:0]   wt_idx,
  input  logic [WEIGHT_W-1:0]         wt_data,
  output logic [NREQ-1:0]             grant,
  output logic                        grant_valid,
  output logic [id_width(NREQ)-1:0]   grant_id,
  output logic [NREQ-1:0]             ready,
  output logic                        timeout_pulse
);

  localparam int ID_W = id_width(NREQ);
  localparam logic [WEIGHT_W-1:0] DEF_W = WEIGHT_W'(DEFAULT_WEIGHT);

  state_t                state_reg, state_next;
  logic [NREQ-1:0]       grant_reg, grant_next;
  logic [ID_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [WEIGHT_W-1:0]   weight_reg  [NREQ];
  logic [WEIGHT_W-1:0]   credit_reg  [NREQ];
  logic [WEIGHT_W-1:0]   credit_next [NREQ];
  // Credits after this cycle's decrement/zeroing, before any reload.
  logic [WEIGHT_W-1:0]   credit_base [NREQ];
  logic [WEIGHT_W-1:0]   reload_val  [NREQ];
  logic [NREQ-1:0]       credit_nz;

  logic [ID_W-1:0]       g_idx, g_after;
  logic [WEIGHT_W-1:0]   credit_dec;
  logic                  do_pick, force_release, timeout_hit;
  logic [ID_W-1:0]       pick_start;
  logic [NREQ-1:0]       pick_a_onehot, pick_b_onehot;
  logic                  pick_a_found, pick_b_found;

  assign g_idx      = ID_W'(onehot_to_idx(32'(grant_reg)));
  assign g_after    = (g_idx == ID_W'(NREQ - 1)) ? '0 : g_idx + 1'b1;
  assign credit_dec = (credit_reg[g_idx] == '0) ? '0 : credit_reg[g_idx] - 1'b1;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_credit
    assign credit_nz[gi]  = |credit_base[gi];
    // A zero weight still earns one transfer per round.
    assign reload_val[gi] = (weight_reg[gi] == '0) ? WEIGHT_W'(1) : weight_reg[gi];
  end

  // First search honours remaining credit; second assumes every credit reloaded.
  rr_pick #(.N(NREQ), .IDW(ID_W)) u_pick_credit (
    .elig   (req & credit_nz),
    .start  (pick_start),
    .onehot (pick_a_onehot),
    .found  (pick_a_found)
  );

  rr_pick #(.N(NREQ), .IDW(ID_W)) u_pick_reload (
    .elig   (req),
    .start  (pick_start),
    .onehot (pick_b_onehot),
    .found  (pick_b_found)
  );

  // Decide whether a new pick is needed this cycle, from where, and the credit update.
  always_comb begin
    do_pick       = 1'b0;
    pick_start    = rr_ptr_reg;
    rr_ptr_next   = rr_ptr_reg;
    force_release = 1'b0;
    for (int i = 0; i < NREQ; i++) credit_base[i] = credit_reg[i];
    case (state_reg)
      IDLE: begin
        do_pick = |req;
      end
      GRANT: begin
        if (ack) begin
          credit_base[g_idx] = credit_dec;
          // Burst continues only while credit remains and the requester stays.
          if (!((credit_dec != '0) && req[g_idx])) begin
            do_pick     = 1'b1;
            pick_start  = g_after;
            rr_ptr_next = g_after;
          end
        end else if (!req[g_idx]) begin
          // Withdrawal: no credit consumed, pointer left where it was.
          do_pick = 1'b1;
        end else if (timeout_hit) begin
          force_release      = 1'b1;
          credit_base[g_idx] = '0;
          rr_ptr_next        = g_after;
        end
      end
      default: ;
    endcase
  end

  // Next grant/state; reload all credits when no requester has credit left.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    for (int i = 0; i < NREQ; i++) credit_next[i] = credit_base[i];
    if (force_release) begin
      state_next = IDLE;
      grant_next = '0;
    end else if (do_pick) begin
      if (pick_a_found) begin
        state_next = GRANT;
        grant_next = pick_a_onehot;
      end else if (pick_b_found) begin
        state_next = GRANT;
        grant_next = pick_b_onehot;
        for (int i = 0; i < NREQ; i++) credit_next[i] = reload_val[i];
      end else begin
        state_next = IDLE;
        grant_next = '0;
      end
    end
  end

  // Scheduler state, grant, pointer and credits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      for (int i = 0; i < NREQ; i++) credit_reg[i] <= DEF_W;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      for (int i = 0; i < NREQ; i++) credit_reg[i] <= credit_next[i];
    end
  end

  // Weight table; a write is seen only by the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) weight_reg[i] <= DEF_W;
    end else if (wt_wr && (int'(wt_idx) < NREQ)) begin
      weight_reg[wt_idx] <= wt_data;
    end
  end

`ifdef WRR_TIMEOUT_EN
  localparam int TMR_W = id_width(TIMEOUT + 1);

  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             pulse_reg;

  assign timeout_hit = (state_reg == GRANT) && (timer_reg == TMR_W'(TIMEOUT - 1));

  // Count unacknowledged cycles of an unchanged grant.
  always_comb begin
    timer_next = '0;
    if ((state_reg == GRANT) && !ack && (grant_next == grant_reg)) timer_next = timer_reg + 1'b1;
  end

  // Watchdog counter and its one-cycle release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
      pulse_reg <= 1'b0;
    end else begin
      timer_reg <= timer_next;
      pulse_reg <= force_release;
    end
  end

  assign timeout_pulse = pulse_reg;
`else
  // TIMEOUT only matters with the watchdog; this term is constant false.
  assign timeout_hit   = (TIMEOUT < 0);
  assign timeout_pulse = 1'b0;
`endif

  assign grant       = grant_reg;
  assign grant_valid = |grant_reg;
  assign grant_id    = g_idx;
  assign ready       = grant_reg & {NREQ{ack}};

endmodule
